mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS-subset control unit; sits directly upstream of the ALU.
//  Sequences each instruction through fetch/decode/execute/memory/writeback.
//  Drives ALUControl and the ALU operand-mux selects, and consumes the ALU Zero flag for beq.
//  Also drives the memory, IR, PC and register-file write enables.
// PARAMETERS
//  ILLEGAL_HALT  0  1: an unknown opcode parks the FSM in HALT until reset; 0: it returns to FETCH
// PORTS
//  clk         in   1  single clock; all state updates on rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  Op          in   6  IR[31:26]; valid from DECODE onward (IR latched at end of FETCH)
//  Funct       in   6  IR[5:0]; used only in EXECUTE
//  Zero        in   1  ALU Zero flag; sampled only in BRANCH
//  IorD        out  1  memory address select: 0=PC, 1=ALUOut
//  MemWrite    out  1  data memory write enable
//  IRWrite     out  1  instruction register load enable
//  PCEn        out  1  PC load enable = PCWrite | (Branch & Zero)
//  RegDst      out  1  write register select: 0=rt, 1=rd
//  MemtoReg    out  1  write-back data select: 0=ALUOut, 1=memory data
//  RegWrite    out  1  register file write enable
//  ALUSrcA     out  1  ALU A select: 0=PC, 1=register A
//  ALUSrcB     out  2  ALU B select: 00=reg B, 01=const 4, 10=sign-extended imm, 11=imm<<2
//  ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  PCSrc       out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
//  IllegalOp   out  1  1-cycle pulse in DECODE when Op is unsupported
//  State       out  4  current state encoding (debug)
// BEHAVIOUR
//  State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6,
//   ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, HALT=12. Codes 13-15 -> FETCH on the next edge.
//  Reset: while rst_n=0 the state is FETCH and every enable (MemWrite, IRWrite, PCEn, RegWrite) is
//   forced to 0; other outputs show FETCH values. First fetch occurs in the first cycle after release.
//  Reset asserted mid-instruction aborts it immediately; there are no partial writes after assertion.
//  Outputs are Moore (decoded from state) except PCEn, which also uses Zero. Any output not listed
//   below for a state is 0; ALUControl is 010 unless listed.
//  Transitions and asserted outputs:
//   FETCH    -> DECODE; IRWrite, PCWrite, ALUSrcB=01, PCSrc=00  (PC <= PC+4)
//   DECODE   ALUSrcB=11  (branch target into ALUOut). Next state by Op:
//            100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC;
//            000010 -> JUMP; any other -> IllegalOp=1, then HALT if ILLEGAL_HALT else FETCH
//   MEMADR   ALUSrcA=1, ALUSrcB=10; next MEMRD if Op=100011, else MEMWR
//   MEMRD    -> MEMWB; IorD=1
//   MEMWB    -> FETCH; RegWrite, MemtoReg=1, RegDst=0
//   MEMWR    -> FETCH; IorD=1, MemWrite
//   EXECUTE  -> ALUWB; ALUSrcA=1, ALUSrcB=00. ALUControl from Funct:
//            100000->010, 100010->110, 100100->000, 100101->001, 101010->111, others->010
//   ALUWB    -> FETCH; RegWrite, RegDst=1, MemtoReg=0
//   BRANCH   -> FETCH; ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1;
//            PCEn=Zero, evaluated combinationally in this cycle
//   ADDIEXEC -> ADDIWB; ALUSrcA=1, ALUSrcB=10
//   ADDIWB   -> FETCH; RegWrite, RegDst=0, MemtoReg=0
//   JUMP     -> FETCH; PCWrite, PCSrc=10
//   HALT     -> HALT; all enables 0; exit only via rst_n
//  Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//  Op and Funct changing outside DECODE/MEMADR/EXECUTE must not affect outputs; Zero is ignored outside BRANCH.
// TESTING
//  1 lw (Op=100011) from reset: states 0,1,2,3,4,0; IRWrite+PCEn only in FETCH; RegWrite+MemtoReg=1 only in MEMWB
//  2 R-type sub (Op=0, Funct=100010): ALUControl=110 in EXECUTE; RegWrite, RegDst=1 in ALUWB; 4 cycles
//  3 beq with Zero=1 then Zero=0: PCEn=1, PCSrc=01 in BRANCH / PCEn=0; both return to FETCH after 3 cycles
//  4 Op=111111 with ILLEGAL_HALT=0: IllegalOp pulses 1 cycle, then FETCH; with ILLEGAL_HALT=1: State=12, enables stay 0
//  5 rst_n pulled low in MEMWR (asynchronous, mid-cycle): MemWrite drops to 0 at once; State=0; first release cycle is FETCH
//  6 sw then j: MemWrite=1, IorD=1 only in MEMWR; in JUMP, PCSrc=10 and PCEn=1; Zero toggling outside BRANCH has no effect

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, ALU operation and write enables.
module mc_control_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
  } ctrl_t;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  logic   op_supported;

  // Control word for a state; computed for the upcoming state so it can be registered.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c        = '0;
    c.aluctl = 3'b010;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: c.alusrca = 1'b1;
      ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluctl  = 3'b110;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB: c.regwrite = 1'b1;
      JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    op_supported = 1'b1;
    case (Op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (Op)
          6'b100011, 6'b101011: next_state = MEMADR;
          6'b000000:            next_state = EXECUTE;
          6'b000100:            next_state = BRANCH;
          6'b001000:            next_state = ADDIEXEC;
          6'b000010:            next_state = JUMP;
          default:              next_state = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEMADR:   next_state = (Op == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:    next_state = MEMWB;
      EXECUTE:  next_state = ALUWB;
      ADDIEXEC: next_state = ADDIWB;
      HALT:     next_state = HALT;
      default:  next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ctrl  <= state_ctrl(FETCH);
    end else begin
      state <= next_state;
      ctrl  <= state_ctrl(next_state);
    end
  end

  // Enables are gated by rst_n so an asserted reset kills writes within the same cycle.
  assign MemWrite = ctrl.memwrite & rst_n;
  assign IRWrite  = ctrl.irwrite & rst_n;
  assign RegWrite = ctrl.regwrite & rst_n;
  assign PCEn     = (ctrl.pcwrite | (ctrl.branch & Zero)) & rst_n;

  assign IorD     = ctrl.iord;
  assign RegDst   = ctrl.regdst;
  assign MemtoReg = ctrl.memtoreg;
  assign ALUSrcA  = ctrl.alusrca;
  assign ALUSrcB  = ctrl.alusrcb;
  assign PCSrc    = ctrl.pcsrc;
  assign State    = state;

  assign IllegalOp = (state == DECODE) & ~op_supported;

  // Funct is only meaningful while the R-type operation is executing.
  always_comb begin
    ALUControl = ctrl.aluctl;
    if (state == EXECUTE) begin
      case (Funct)
        6'b100010: ALUControl = 3'b110;
        6'b100100: ALUControl = 3'b000;
        6'b100101: ALUControl = 3'b001;
        6'b101010: ALUControl = 3'b111;
        default:   ALUControl = 3'b010;
      endcase
    end
  end

endmodule
